// File: rtl/aip_slave_port.sv
// aip_slave_port: slave-side endpoint of one AIP port.
// It decodes register accesses from the master into a small register map.
// It holds an input buffer (filled by the master, read by the core).
// It holds an output buffer (written by the core, read by the master).
// It provides a start/done handshake with the core and a level interrupt to the master.
// Optional feature: define AIP_SLAVE_TIMEOUT_EN to add a RUN-state watchdog
// that aborts a job after TIMEOUT_CYCLES cycles without core_done.
module aip_slave_port #(
  parameter logic [31:0] IP_ID          = 32'h0000_0001,
  parameter int          BUF_DEPTH      = 16,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset_n,
  input  logic [4:0]                   aip_config,
  input  logic [31:0]                  aip_datain,
  input  logic                         aip_read,
  input  logic                         aip_write,
  input  logic                         aip_start,
  input  logic                         core_int,
  output logic [31:0]                  aip_dataout,
  output logic                         aip_int,
  output logic                         core_start,
  input  logic                         core_done,
  output logic [31:0]                  core_cfg,
  input  logic [$clog2(BUF_DEPTH)-1:0] core_in_addr,
  output logic [31:0]                  core_in_data,
  input  logic                         core_out_we,
  input  logic [$clog2(BUF_DEPTH)-1:0] core_out_addr,
  input  logic [31:0]                  core_out_data
);

  localparam int AW = $clog2(BUF_DEPTH);

  localparam logic [4:0] ADDR_ID       = 5'h00;
  localparam logic [4:0] ADDR_STATUS   = 5'h01;
  localparam logic [4:0] ADDR_IN_PTR   = 5'h02;
  localparam logic [4:0] ADDR_IN_DATA  = 5'h03;
  localparam logic [4:0] ADDR_OUT_PTR  = 5'h04;
  localparam logic [4:0] ADDR_OUT_DATA = 5'h05;
  localparam logic [4:0] ADDR_CFG      = 5'h06;
  localparam logic [4:0] ADDR_IRQ_EN   = 5'h07;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [31:0]   in_buf  [BUF_DEPTH];
  logic [31:0]   out_buf [BUF_DEPTH];
  logic [AW-1:0] in_ptr;
  logic [AW-1:0] out_ptr;
  logic [3:0]    irq_en;
  logic          st_done;
  logic          st_start_err;
  logic          st_host_int;
  logic          st_timeout;
  logic          core_int_q;
  logic [31:0]   read_data;
  logic [3:0]    w1c;
  logic [3:0]    flags;
  logic          start_pulse;
  logic          set_done;
  logic          set_start_err;
  logic          set_timeout;
  logic          tmo_expire;
  logic          busy;

  // Write and read strobes for each register.
  logic wr_status, wr_in_ptr, wr_in_data, wr_out_ptr, wr_cfg, wr_irq_en, rd_out_data;
  assign wr_status   = aip_write && (aip_config == ADDR_STATUS);
  assign wr_in_ptr   = aip_write && (aip_config == ADDR_IN_PTR);
  assign wr_in_data  = aip_write && (aip_config == ADDR_IN_DATA);
  assign wr_out_ptr  = aip_write && (aip_config == ADDR_OUT_PTR);
  assign wr_cfg      = aip_write && (aip_config == ADDR_CFG);
  assign wr_irq_en   = aip_write && (aip_config == ADDR_IRQ_EN);
  assign rd_out_data = aip_read  && (aip_config == ADDR_OUT_DATA);

  assign busy  = (state == RUN);
  assign flags = {st_timeout, st_host_int, st_start_err, st_done};
  assign w1c   = wr_status ? aip_datain[4:1] : 4'b0000;

`ifdef AIP_SLAVE_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // The watchdog counts RUN cycles and restarts from zero whenever the FSM is idle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tmo_cnt <= '0;
    end else if (state != RUN) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  assign tmo_expire = (state == RUN) && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_expire = 1'b0;
`endif

  // Master-side input buffer write; buffer storage is not reset.
  always_ff @(posedge clk_clk) begin
    if (wr_in_data) begin
      in_buf[in_ptr] <= aip_datain;
    end
  end

  // Core-side output buffer write; the master read path samples the old word on a collision.
  always_ff @(posedge clk_clk) begin
    if (core_out_we) begin
      out_buf[core_out_addr] <= core_out_data;
    end
  end

  // Registered core read port of the input buffer (one cycle latency).
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      core_in_data <= '0;
    end else begin
      core_in_data <= in_buf[core_in_addr];
    end
  end

  // Buffer pointers: explicit writes win over auto-increment, and increments wrap naturally.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      in_ptr  <= '0;
      out_ptr <= '0;
    end else begin
      if (wr_in_ptr) begin
        in_ptr <= aip_datain[AW-1:0];
      end else if (wr_in_data) begin
        in_ptr <= in_ptr + AW'(1);
      end
      if (wr_out_ptr) begin
        out_ptr <= aip_datain[AW-1:0];
      end else if (rd_out_data) begin
        out_ptr <= out_ptr + AW'(1);
      end
    end
  end

  // Plain read/write configuration registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      core_cfg <= '0;
      irq_en   <= '0;
    end else begin
      if (wr_cfg) begin
        core_cfg <= aip_datain;
      end
      if (wr_irq_en) begin
        irq_en <= aip_datain[4:1];
      end
    end
  end

  // Read mux from current state, so a same-cycle write is not visible yet.
  always_comb begin
    read_data = '0;
    case (aip_config)
      ADDR_ID:       read_data = IP_ID;
      ADDR_STATUS:   read_data = {27'd0, flags, busy};
      ADDR_IN_PTR:   read_data = 32'(in_ptr);
      ADDR_OUT_PTR:  read_data = 32'(out_ptr);
      ADDR_OUT_DATA: read_data = out_buf[out_ptr];
      ADDR_CFG:      read_data = core_cfg;
      ADDR_IRQ_EN:   read_data = {27'd0, irq_en, 1'b0};
      default:       read_data = '0;
    endcase
  end

  // Read data register updates only on a read strobe and holds otherwise.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      aip_dataout <= '0;
    end else if (aip_read) begin
      aip_dataout <= read_data;
    end
  end

  // FSM next-state and event decode; core_done has priority over a coinciding watchdog expiry.
  always_comb begin
    state_next    = state;
    start_pulse   = 1'b0;
    set_done      = 1'b0;
    set_start_err = 1'b0;
    set_timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (aip_start) begin
          state_next  = RUN;
          start_pulse = 1'b1;
        end
      end
      RUN: begin
        if (aip_start) begin
          set_start_err = 1'b1;
        end
        if (core_done) begin
          state_next = IDLE;
          set_done   = 1'b1;
        end else if (tmo_expire) begin
          state_next  = IDLE;
          set_timeout = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register and the registered start pulse to the core.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= IDLE;
      core_start <= 1'b0;
    end else begin
      state      <= state_next;
      core_start <= start_pulse;
    end
  end

  // Sticky status flags with write-one-to-clear; a set event in the same cycle wins.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      st_done      <= 1'b0;
      st_start_err <= 1'b0;
      st_host_int  <= 1'b0;
      st_timeout   <= 1'b0;
      core_int_q   <= 1'b0;
    end else begin
      core_int_q   <= core_int;
      st_done      <= set_done | (st_done & ~w1c[0]);
      st_start_err <= set_start_err | (st_start_err & ~w1c[1]);
      st_host_int  <= (core_int & ~core_int_q) | (st_host_int & ~w1c[2]);
      st_timeout   <= set_timeout | (st_timeout & ~w1c[3]);
    end
  end

  // Interrupt to the master, registered one cycle behind the flags.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      aip_int <= 1'b0;
    end else begin
      aip_int <= |(flags & irq_en);
    end
  end

endmodule
